// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: shared types and constants for the program-counter generator.
//   pc_state_t  : FSM state encoding (IDLE=0, RUN=1, HALT=2)
//   PC_INC      : sequential fetch increment in bytes
//   RAS_PTR_W   : top-pointer width for the default return-address-stack depth
package pc_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } pc_state_t;

    localparam int PC_INC         = 4;
    localparam int RAS_DEPTH_DFLT = 4;
    localparam int RAS_PTR_W      = $clog2(RAS_DEPTH_DFLT);

endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack with a top pointer.
//   i_clk        : clock, rising edge
//   i_rst_n      : synchronous active-low reset (count, pointer and all entries to 0)
//   i_clear      : empty the stack (count and pointer to 0)
//   i_push       : write i_push_data as the new top entry
//   i_pop        : discard the top entry (no effect when empty)
//   i_push_data  : value to push
//   o_top        : current top entry
//   o_empty      : count == 0
//   o_full       : count == RAS_DEPTH
// Push together with pop on a non-empty stack replaces the top entry.
// Push when full overwrites the oldest entry, which is the slot after top.
module pc_ras
    import pc_gen_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4,
    parameter int PTR_W     = RAS_PTR_W
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_clear,
    input  logic            i_push,
    input  logic            i_pop,
    input  logic [XLEN-1:0] i_push_data,
    output logic [XLEN-1:0] o_top,
    output logic            o_empty,
    output logic            o_full
);

    logic [XLEN-1:0] r_mem [RAS_DEPTH];
    logic [PTR_W-1:0] r_top;
    logic [PTR_W:0]   r_cnt;

    logic [PTR_W-1:0] w_top_inc;
    logic             w_empty;
    logic             w_full;

    assign w_top_inc = r_top + 1'b1;
    assign w_empty   = (r_cnt == '0);
    assign w_full    = (r_cnt == (PTR_W+1)'(RAS_DEPTH));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_top <= '0;
            r_cnt <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_clear) begin
            r_top <= '0;
            r_cnt <= '0;
        end else if (i_push && i_pop && !w_empty) begin
            r_mem[r_top] <= i_push_data;
        end else if (i_push) begin
            r_top            <= w_top_inc;
            r_mem[w_top_inc] <= i_push_data;
            if (!w_full) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end else if (i_pop && !w_empty) begin
            r_top <= r_top - 1'b1;
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_top   = r_mem[r_top];
    assign o_empty = w_empty;
    assign o_full  = w_full;

endmodule

// File: rtl/pc_gen.sv
// pc_gen: program-counter generator at the head of the fetch stage.
//   clk_i, rst_i        : clock and synchronous active-low reset
//   start_i             : run enable (level)
//   stall_i             : hold PC and RAS in RUN
//   halt_i              : RUN -> HALT
//   flush_i/flush_pc_i  : trap redirect, overrides stall
//   br_taken_i/br_target_i : taken branch redirect
//   call_i / ret_i      : RAS push of pc_o+4 / RAS pop and jump
//   pc_o                : registered fetch address
//   pc_valid_o, state_o : decoded from the registered state only
//   ras_empty_o/ras_full_o : stack occupancy flags
//   ret_underflow_o     : registered pulse after a ret accepted on an empty RAS
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter int              RAS_DEPTH = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic            stall_i,
    input  logic            halt_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] flush_pc_i,
    input  logic            br_taken_i,
    input  logic [XLEN-1:0] br_target_i,
    input  logic            call_i,
    input  logic            ret_i,
    output logic [XLEN-1:0] pc_o,
    output logic            pc_valid_o,
    output logic [1:0]      state_o,
    output logic            ras_empty_o,
    output logic            ras_full_o,
    output logic            ret_underflow_o
);

    pc_state_t       r_state;
    logic [XLEN-1:0] r_pc;
    logic            r_underflow;

    pc_state_t       w_state_nxt;
    logic [XLEN-1:0] w_pc_nxt;
    logic [XLEN-1:0] w_pc_inc;
    logic            w_underflow_nxt;
    logic            w_push;
    logic            w_pop;
    logic            w_clear;
    logic [XLEN-1:0] w_ras_top;
    logic            w_ras_empty;
    logic            w_ras_full;

    // Modulo-2^XLEN increment: the carry out is simply dropped.
    assign w_pc_inc = r_pc + XLEN'(PC_INC);

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state     <= ST_IDLE;
            r_pc        <= RESET_VEC;
            r_underflow <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_underflow <= w_underflow_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_underflow_nxt = 1'b0;
        w_push          = 1'b0;
        w_pop           = 1'b0;
        w_clear         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // PC is pinned to the reset vector; leaving IDLE keeps it so the
                // first fetch in RUN is RESET_VEC.
                w_pc_nxt = RESET_VEC;
                w_clear  = 1'b1;
                if (start_i) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                // Dropping start only takes effect once the stall has released.
                if (!start_i && !stall_i) begin
                    w_state_nxt = ST_IDLE;
                    w_pc_nxt    = RESET_VEC;
                    w_clear     = 1'b1;
                end else if (flush_i) begin
                    w_pc_nxt = flush_pc_i;
                end else if (stall_i) begin
                    w_pc_nxt = r_pc;
                end else if (halt_i) begin
                    w_state_nxt = ST_HALT;
                end else if (br_taken_i) begin
                    w_pc_nxt = br_target_i;
                    w_push   = call_i;
                end else if (ret_i && !w_ras_empty) begin
                    w_pc_nxt = w_ras_top;
                    w_pop    = 1'b1;
                    w_push   = call_i;
                end else if (ret_i) begin
                    w_pc_nxt        = w_pc_inc;
                    w_underflow_nxt = 1'b1;
                    w_push          = call_i;
                end else begin
                    w_pc_nxt = w_pc_inc;
                    w_push   = call_i;
                end
            end
            ST_HALT: begin
                if (flush_i) begin
                    w_state_nxt = ST_RUN;
                    w_pc_nxt    = flush_pc_i;
                end else if (!start_i) begin
                    w_state_nxt = ST_IDLE;
                    w_pc_nxt    = RESET_VEC;
                    w_clear     = 1'b1;
                end
            end
            default: begin
                // Unreachable encoding recovers through IDLE.
                w_state_nxt = ST_IDLE;
                w_pc_nxt    = RESET_VEC;
                w_clear     = 1'b1;
            end
        endcase
    end

    always_comb begin
        pc_o            = r_pc;
        pc_valid_o      = (r_state == ST_RUN);
        state_o         = r_state;
        ret_underflow_o = r_underflow;
        ras_empty_o     = w_ras_empty;
        ras_full_o      = w_ras_full;
    end

    pc_ras #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH),
        .PTR_W     ($clog2(RAS_DEPTH))
    ) u_ras (
        .i_clk       (clk_i),
        .i_rst_n     (rst_i),
        .i_clear     (w_clear),
        .i_push      (w_push),
        .i_pop       (w_pop),
        .i_push_data (w_pc_inc),
        .o_top       (w_ras_top),
        .o_empty     (w_ras_empty),
        .o_full      (w_ras_full)
    );

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed bench for pc_gen with an expectation queue.
// Each step drives inputs, queues the values expected after the next rising
// edge, then samples 1 time unit after that edge and compares.
module tb_pc_gen;

    logic        clk;
    logic        rst;
    logic        start;
    logic        stall;
    logic        halt;
    logic        flush;
    logic [31:0] flush_pc;
    logic        br;
    logic [31:0] br_tgt;
    logic        call;
    logic        ret;
    logic [31:0] pc;
    logic        pc_valid;
    logic [1:0]  state;
    logic        ras_empty;
    logic        ras_full;
    logic        ret_unf;

    typedef struct {
        logic [31:0] pc;
        logic        vld;
        logic [1:0]  st;
        logic        emp;
        logic        ful;
        logic        unf;
    } exp_t;

    exp_t sb[$];
    int   checks;
    int   errors;

    pc_gen #(
        .XLEN      (32),
        .RESET_VEC (32'h0),
        .RAS_DEPTH (4)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .start_i         (start),
        .stall_i         (stall),
        .halt_i          (halt),
        .flush_i         (flush),
        .flush_pc_i      (flush_pc),
        .br_taken_i      (br),
        .br_target_i     (br_tgt),
        .call_i          (call),
        .ret_i           (ret),
        .pc_o            (pc),
        .pc_valid_o      (pc_valid),
        .state_o         (state),
        .ras_empty_o     (ras_empty),
        .ras_full_o      (ras_full),
        .ret_underflow_o (ret_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clr_in();
        stall = 0; halt = 0; flush = 0; flush_pc = 0;
        br = 0; br_tgt = 0; call = 0; ret = 0;
    endtask

    // Queue expectation, advance one edge, pop and compare.
    task automatic step(input string tag, input logic [31:0] e_pc, input logic e_vld,
                        input logic [1:0] e_st, input logic e_emp, input logic e_ful,
                        input logic e_unf);
        exp_t e;
        sb.push_back('{pc: e_pc, vld: e_vld, st: e_st, emp: e_emp, ful: e_ful, unf: e_unf});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s observed=empty-queue expected=entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, ".pc"}, pc, e.pc);
            chk({tag, ".vld"}, {31'b0, pc_valid}, {31'b0, e.vld});
            chk({tag, ".st"}, {30'b0, state}, {30'b0, e.st});
            chk({tag, ".emp"}, {31'b0, ras_empty}, {31'b0, e.emp});
            chk({tag, ".ful"}, {31'b0, ras_full}, {31'b0, e.ful});
            chk({tag, ".unf"}, {31'b0, ret_unf}, {31'b0, e.unf});
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 0; start = 0;
        clr_in();

        // Reset state
        step("rst0", 32'h0, 0, 2'd0, 1, 0, 0);
        step("rst1", 32'h0, 0, 2'd0, 1, 0, 0);

        // Start: first fetch is RESET_VEC, then sequential
        rst = 1; start = 1;
        step("start", 32'h0, 1, 2'd1, 1, 0, 0);
        step("seq4",  32'h4, 1, 2'd1, 1, 0, 0);
        step("seq8",  32'h8, 1, 2'd1, 1, 0, 0);

        // Stall ignores branch, flush overrides stall
        flush = 1; flush_pc = 32'h100;
        step("fl100", 32'h100, 1, 2'd1, 1, 0, 0);
        clr_in(); stall = 1; br = 1; br_tgt = 32'h400;
        step("stall0", 32'h100, 1, 2'd1, 1, 0, 0);
        step("stall1", 32'h100, 1, 2'd1, 1, 0, 0);
        step("stall2", 32'h100, 1, 2'd1, 1, 0, 0);
        flush = 1; flush_pc = 32'h80;
        step("flstall", 32'h80, 1, 2'd1, 1, 0, 0);

        // Call via branch, then return
        clr_in(); flush = 1; flush_pc = 32'h10;
        step("fl10", 32'h10, 1, 2'd1, 1, 0, 0);
        clr_in(); br = 1; br_tgt = 32'h200; call = 1;
        step("callbr", 32'h200, 1, 2'd1, 0, 0, 0);
        clr_in();
        step("s204", 32'h204, 1, 2'd1, 0, 0, 0);
        step("s208", 32'h208, 1, 2'd1, 0, 0, 0);
        ret = 1;
        step("ret14", 32'h14, 1, 2'd1, 1, 0, 0);

        // Five calls into a 4-deep RAS: oldest (0x1C) overwritten
        clr_in();
        step("s18", 32'h18, 1, 2'd1, 1, 0, 0);
        call = 1;
        step("callA", 32'h1C, 1, 2'd1, 0, 0, 0);
        step("callB", 32'h20, 1, 2'd1, 0, 0, 0);
        step("callC", 32'h24, 1, 2'd1, 0, 0, 0);
        step("callD", 32'h28, 1, 2'd1, 0, 1, 0);
        step("callE", 32'h2C, 1, 2'd1, 0, 1, 0);
        clr_in(); ret = 1;
        step("popE", 32'h2C, 1, 2'd1, 0, 0, 0);
        step("popD", 32'h28, 1, 2'd1, 0, 0, 0);
        step("popC", 32'h24, 1, 2'd1, 0, 0, 0);
        step("popB", 32'h20, 1, 2'd1, 1, 0, 0);
        step("unf",  32'h24, 1, 2'd1, 1, 0, 1);
        clr_in();
        step("unfclr", 32'h28, 1, 2'd1, 1, 0, 0);

        // Halt, flush back to RUN, then stop to IDLE
        flush = 1; flush_pc = 32'h40;
        step("fl40", 32'h40, 1, 2'd1, 1, 0, 0);
        clr_in(); halt = 1;
        step("halt", 32'h40, 0, 2'd2, 1, 0, 0);
        clr_in(); stall = 1;
        step("hstall", 32'h40, 0, 2'd2, 1, 0, 0);
        clr_in(); flush = 1; flush_pc = 32'h1000;
        step("hflush", 32'h1000, 1, 2'd1, 1, 0, 0);
        clr_in(); call = 1;
        step("call1k", 32'h1004, 1, 2'd1, 0, 0, 0);
        clr_in(); start = 0; stall = 1;
        step("stopwait", 32'h1004, 1, 2'd1, 0, 0, 0);
        stall = 0;
        step("stop", 32'h0, 0, 2'd0, 1, 0, 0);

        // Wraparound and call+ret top replacement
        start = 1;
        step("restart", 32'h0, 1, 2'd1, 1, 0, 0);
        flush = 1; flush_pc = 32'hFFFF_FFFC;
        step("flmax", 32'hFFFF_FFFC, 1, 2'd1, 1, 0, 0);
        clr_in();
        step("wrap", 32'h0, 1, 2'd1, 1, 0, 0);
        step("w4", 32'h4, 1, 2'd1, 1, 0, 0);
        call = 1;
        step("c8", 32'h8, 1, 2'd1, 0, 0, 0);
        step("cC", 32'hC, 1, 2'd1, 0, 0, 0);
        ret = 1;
        step("retcall", 32'hC, 1, 2'd1, 0, 0, 0);
        call = 0;
        step("ret10", 32'h10, 1, 2'd1, 0, 0, 0);
        step("ret8", 32'h8, 1, 2'd1, 1, 0, 0);
        clr_in();
        step("sC", 32'hC, 1, 2'd1, 1, 0, 0);

        // Reset mid-run
        rst = 0;
        step("midrst", 32'h0, 0, 2'd0, 1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
